axi_req_sched: RTL and testbench
================================

// Module: axi_req_sched
// PURPOSE
//  Request scheduler in front of AXI_Interface: owns its simple read/write ports, shares them among
//  I-cache refill, D-side read and D-side posted writes. Buffers writes, blocks D reads that hit a
//  buffered write (RAW), never issues while flush is high, returns read data to the right requester.
// PARAMETERS
//  WBUF_DEPTH  4   posted-write FIFO entries (power of 2, >=2)
//  LEN_W       4   burst length field width (axir_ilen)
// PORTS
//  aclk        in   1   clock
//  areset      in   1   async reset, active-high
//  flush       in   1   pipeline flush
//  ir_req/ir_addr/ir_len  in 1/32/LEN_W  I refill request, held until ir_ack
//  ir_ack      out  1   I request accepted (1-cycle pulse)
//  ir_valid/ir_last/ir_data  out 1/1/32  I return beat
//  dr_req/dr_addr  in 1/32  D single-word read, held until dr_ack
//  dr_ack      out  1   D read accepted (pulse)
//  dr_valid/dr_data  out 1/32  D return word
//  dw_req/dw_addr/dw_data/dw_strb  in 1/32/32/4  D write; accepted when dw_ack=1
//  dw_ack      out  1   = !wb_full (combinational)
//  wb_empty    out  1   write buffer empty (for sync/cache ops)
//  axir_ireq/axir_iaddr/axir_ilen  out 1/32/LEN_W  to interface
//  axir_dreq/axir_daddr  out 1/32  to interface
//  axir_rid/axir_rdy/axir_last/axir_data  in 1/1/1/32  from interface (rid 0=I,1=D)
//  axiw_req/axiw_addr/axiw_data/axiw_sel  out 1/32/32/32  axiw_sel[3:0]=strb, [31:4]=0
//  axiw_rdy    in   1   write completed
// BEHAVIOUR
//  Reset: all outputs 0, wb_empty=1, FIFO ptrs/count 0, all FSMs IDLE. Mid-op reset abandons all.
//  All axir_*/axiw_* requests are 1-cycle pulses, never asserted when flush=1.
//  I FSM: I_IDLE -(ir_req&!flush)-> I_DATA, same edge pulses axir_ireq+ir_ack, addr/len registered.
//   I_DATA: each axir_rdy&rid==0 -> ir_valid/ir_data/ir_last next cycle; on last -> I_IDLE.
//  D FSM: D_IDLE -(dr_req&!flush)-> D_HAZ if dr_addr[31:2] matches any valid wbuf entry, else
//   D_DATA with axir_dreq+dr_ack pulse. D_HAZ: latched addr; issue+ack when no match and !flush.
//   D_DATA: axir_rdy&rid==1 -> dr_valid next cycle -> D_IDLE.
//  Flush in I_DATA/D_DATA: set drop flag; remaining beats consumed, ir_valid/dr_valid suppressed;
//   flag cleared on last beat. Flush in D_HAZ: -> D_IDLE, no ack. Writes are never dropped.
//  Write buffer: push on dw_req&dw_ack; W_IDLE -(!empty&!flush)-> W_BUSY pulsing axiw_req with
//   head entry; W_BUSY -(axiw_rdy)-> W_IDLE, pop. Full: dw_ack=0, no bypass even if popping.
//   Push+pop same cycle: count unchanged. Pointers wrap mod WBUF_DEPTH. Strict FIFO order.
//  Hazard compare includes entry in W_BUSY (not yet popped) and excludes same-cycle push.
//  Latency: request->axir pulse 0 extra cycles from accept edge; axir_rdy->requester valid 1 cycle.
//  I and D reads may be outstanding concurrently; interface arbitrates AR channel.
// STRUCTURE
//  Package axi_sched_pkg: I/D/W state enums, RID_I=1'b0, RID_D=1'b1, WB entry struct
//   {addr[31:0],data[31:0],strb[3:0]}.
//  Sub-module axi_wbuf: FIFO with per-entry word-address match output (match vector OR-reduced).
// TESTING
//  1 ir_req addr 0x1FC0_0000 len 3 -> one axir_ireq pulse, 4 beats -> 4 ir_valid, ir_last on 4th.
//  2 dw 0x100 data 0xDEAD_BEEF then dr 0x100 -> D_HAZ, axir_dreq only after axiw_rdy; dr_data=mem.
//  3 fill 4 writes with axiw_rdy held 0 -> dw_ack=0 on 5th; release -> drained in order, wb_empty=1.
//  4 flush during I burst beat 2 of 4 -> no ir_valid for beats 2-4, next ir_req issues after last.
//  5 ir_req and dr_req same cycle with flush=1 -> no pulses; flush drops -> both issued same edge.
//  6 areset asserted mid D_DATA and W_BUSY -> all outputs 0 async, wb_empty=1, no stray pulses.

Source files
------------

// File: rtl/axi_sched_pkg.sv
// Shared types for the AXI request scheduler: FSM state encodings, read-ID
// values and the posted-write buffer entry layout.
package axi_sched_pkg;

  typedef enum logic {I_IDLE, I_DATA} i_state_e;
  typedef enum logic [1:0] {D_IDLE, D_HAZ, D_DATA} d_state_e;
  typedef enum logic {W_IDLE, W_BUSY} w_state_e;

  localparam logic RID_I = 1'b0;
  localparam logic RID_D = 1'b1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wb_entry_t;

endpackage

// File: rtl/axi_wbuf.sv
// Posted-write FIFO with a word-address match against every occupied entry,
// used by the scheduler to hold back D-side reads that would bypass a write.
module axi_wbuf
  import axi_sched_pkg::*;
#(
  parameter int WBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  wb_entry_t   push_entry,
  input  logic        pop,
  output wb_entry_t   head,
  output logic        full,
  output logic        empty,
  input  logic [29:0] match_waddr,
  output logic        match
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  wb_entry_t        mem_q [WBUF_DEPTH];
  logic [WBUF_DEPTH-1:0] match_vec;
  logic [PTR_W-1:0] off;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
  end

  // An entry is occupied when its distance from the read pointer is below count.
  always_comb begin
    off       = '0;
    match_vec = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      off          = PTR_W'(i) - rd_ptr_q;
      match_vec[i] = ({1'b0, off} < count_q) && (mem_q[i].addr[31:2] == match_waddr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(WBUF_DEPTH));
  assign empty = (count_q == '0);
  assign match = |match_vec;

endmodule

// File: rtl/axi_req_sched.sv
// Shares the AXI interface read/write ports between I-cache refill, D-side
// reads and buffered D-side writes, holding D reads that hit a pending write.
module axi_req_sched
  import axi_sched_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int LEN_W      = 4
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             flush,
  input  logic             ir_req,
  input  logic [31:0]      ir_addr,
  input  logic [LEN_W-1:0] ir_len,
  output logic             ir_ack,
  output logic             ir_valid,
  output logic             ir_last,
  output logic [31:0]      ir_data,
  input  logic             dr_req,
  input  logic [31:0]      dr_addr,
  output logic             dr_ack,
  output logic             dr_valid,
  output logic [31:0]      dr_data,
  input  logic             dw_req,
  input  logic [31:0]      dw_addr,
  input  logic [31:0]      dw_data,
  input  logic [3:0]       dw_strb,
  output logic             dw_ack,
  output logic             wb_empty,
  output logic             axir_ireq,
  output logic [31:0]      axir_iaddr,
  output logic [LEN_W-1:0] axir_ilen,
  output logic             axir_dreq,
  output logic [31:0]      axir_daddr,
  input  logic             axir_rid,
  input  logic             axir_rdy,
  input  logic             axir_last,
  input  logic [31:0]      axir_data,
  output logic             axiw_req,
  output logic [31:0]      axiw_addr,
  output logic [31:0]      axiw_data,
  output logic [31:0]      axiw_sel,
  input  logic             axiw_rdy
);

  i_state_e i_state_q, i_state_d;
  d_state_e d_state_q, d_state_d;
  w_state_e w_state_q, w_state_d;

  logic             ireq_q, ireq_d, ir_ack_q, ir_ack_d, idrop_q, idrop_d;
  logic             ir_valid_q, ir_valid_d, ir_last_q, ir_last_d;
  logic [31:0]      ir_data_q, ir_data_d, iaddr_q, iaddr_d;
  logic [LEN_W-1:0] ilen_q, ilen_d;
  logic             dreq_q, dreq_d, dr_ack_q, dr_ack_d, ddrop_q, ddrop_d;
  logic             dr_valid_q, dr_valid_d;
  logic [31:0]      dr_data_q, dr_data_d, daddr_q, daddr_d;
  logic             wreq_q, wreq_d;
  logic [31:0]      waddr_q, waddr_d, wdata_q, wdata_d;
  logic [3:0]       wstrb_q, wstrb_d;

  logic        wb_full, wb_emp, wb_push, wb_pop, wb_match;
  logic [29:0] match_waddr;
  wb_entry_t   push_entry, head;

  always_comb begin
    push_entry.addr = dw_addr;
    push_entry.data = dw_data;
    push_entry.strb = dw_strb;
  end

  assign wb_push     = dw_req && !wb_full;
  assign wb_pop      = (w_state_q == W_BUSY) && axiw_rdy;
  assign match_waddr = (d_state_q == D_IDLE) ? dr_addr[31:2] : daddr_q[31:2];

  axi_wbuf #(.WBUF_DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk         (aclk),
    .rst         (areset),
    .push        (wb_push),
    .push_entry  (push_entry),
    .pop         (wb_pop),
    .head        (head),
    .full        (wb_full),
    .empty       (wb_emp),
    .match_waddr (match_waddr),
    .match       (wb_match)
  );

  always_comb begin
    i_state_d  = i_state_q;
    ireq_d     = 1'b0;
    ir_ack_d   = 1'b0;
    ir_valid_d = 1'b0;
    ir_last_d  = 1'b0;
    ir_data_d  = ir_data_q;
    iaddr_d    = iaddr_q;
    ilen_d     = ilen_q;
    idrop_d    = idrop_q;
    case (i_state_q)
      I_IDLE: begin
        if (ir_req && !flush) begin
          i_state_d = I_DATA;
          ireq_d    = 1'b1;
          ir_ack_d  = 1'b1;
          iaddr_d   = ir_addr;
          ilen_d    = ir_len;
          idrop_d   = 1'b0;
        end
      end
      default: begin
        if (flush) idrop_d = 1'b1;
        if (axir_rdy && axir_rid == RID_I) begin
          // A beat arriving in the flush cycle is already stale.
          ir_valid_d = !(idrop_q || flush);
          ir_last_d  = axir_last && !(idrop_q || flush);
          ir_data_d  = axir_data;
          if (axir_last) begin
            i_state_d = I_IDLE;
            idrop_d   = 1'b0;
          end
        end
      end
    endcase
  end

  always_comb begin
    d_state_d  = d_state_q;
    dreq_d     = 1'b0;
    dr_ack_d   = 1'b0;
    dr_valid_d = 1'b0;
    dr_data_d  = dr_data_q;
    daddr_d    = daddr_q;
    ddrop_d    = ddrop_q;
    case (d_state_q)
      D_IDLE: begin
        if (dr_req && !flush) begin
          daddr_d = dr_addr;
          ddrop_d = 1'b0;
          if (wb_match) begin
            d_state_d = D_HAZ;
          end else begin
            d_state_d = D_DATA;
            dreq_d    = 1'b1;
            dr_ack_d  = 1'b1;
          end
        end
      end
      D_HAZ: begin
        if (flush) begin
          d_state_d = D_IDLE;
        end else if (!wb_match) begin
          d_state_d = D_DATA;
          dreq_d    = 1'b1;
          dr_ack_d  = 1'b1;
        end
      end
      default: begin
        if (flush) ddrop_d = 1'b1;
        if (axir_rdy && axir_rid == RID_D) begin
          dr_valid_d = !(ddrop_q || flush);
          dr_data_d  = axir_data;
          d_state_d  = D_IDLE;
          ddrop_d    = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    wreq_d    = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (!wb_emp && !flush) begin
          w_state_d = W_BUSY;
          wreq_d    = 1'b1;
          waddr_d   = head.addr;
          wdata_d   = head.data;
          wstrb_d   = head.strb;
        end
      end
      default: begin
        if (axiw_rdy) w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      i_state_q  <= I_IDLE;
      d_state_q  <= D_IDLE;
      w_state_q  <= W_IDLE;
      ireq_q     <= 1'b0;
      ir_ack_q   <= 1'b0;
      ir_valid_q <= 1'b0;
      ir_last_q  <= 1'b0;
      ir_data_q  <= '0;
      iaddr_q    <= '0;
      ilen_q     <= '0;
      idrop_q    <= 1'b0;
      dreq_q     <= 1'b0;
      dr_ack_q   <= 1'b0;
      dr_valid_q <= 1'b0;
      dr_data_q  <= '0;
      daddr_q    <= '0;
      ddrop_q    <= 1'b0;
      wreq_q     <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      i_state_q  <= i_state_d;
      d_state_q  <= d_state_d;
      w_state_q  <= w_state_d;
      ireq_q     <= ireq_d;
      ir_ack_q   <= ir_ack_d;
      ir_valid_q <= ir_valid_d;
      ir_last_q  <= ir_last_d;
      ir_data_q  <= ir_data_d;
      iaddr_q    <= iaddr_d;
      ilen_q     <= ilen_d;
      idrop_q    <= idrop_d;
      dreq_q     <= dreq_d;
      dr_ack_q   <= dr_ack_d;
      dr_valid_q <= dr_valid_d;
      dr_data_q  <= dr_data_d;
      daddr_q    <= daddr_d;
      ddrop_q    <= ddrop_d;
      wreq_q     <= wreq_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign ir_ack     = ir_ack_q;
  assign ir_valid   = ir_valid_q;
  assign ir_last    = ir_last_q;
  assign ir_data    = ir_data_q;
  assign dr_ack     = dr_ack_q;
  assign dr_valid   = dr_valid_q;
  assign dr_data    = dr_data_q;
  assign dw_ack     = !wb_full;
  assign wb_empty   = wb_emp;
  assign axir_ireq  = ireq_q;
  assign axir_iaddr = iaddr_q;
  assign axir_ilen  = ilen_q;
  assign axir_dreq  = dreq_q;
  assign axir_daddr = daddr_q;
  assign axiw_req   = wreq_q;
  assign axiw_addr  = waddr_q;
  assign axiw_data  = wdata_q;
  assign axiw_sel   = {28'b0, wstrb_q};

endmodule

// File: tb/tb_axi_req_sched.sv
// Directed bench for axi_req_sched: refill bursts, RAW hold-off, write-buffer
// fill/drain, flush handling and asynchronous reset.
module tb_axi_req_sched;

  logic        aclk, areset, flush;
  logic        ir_req;
  logic [31:0] ir_addr;
  logic [3:0]  ir_len;
  logic        ir_ack, ir_valid, ir_last;
  logic [31:0] ir_data;
  logic        dr_req;
  logic [31:0] dr_addr;
  logic        dr_ack, dr_valid;
  logic [31:0] dr_data;
  logic        dw_req;
  logic [31:0] dw_addr, dw_data;
  logic [3:0]  dw_strb;
  logic        dw_ack, wb_empty;
  logic        axir_ireq;
  logic [31:0] axir_iaddr;
  logic [3:0]  axir_ilen;
  logic        axir_dreq;
  logic [31:0] axir_daddr;
  logic        axir_rid, axir_rdy, axir_last;
  logic [31:0] axir_data;
  logic        axiw_req;
  logic [31:0] axiw_addr, axiw_data, axiw_sel;
  logic        axiw_rdy;

  int n_chk = 0;
  int n_fail = 0;
  int ireq_cnt = 0, dreq_cnt = 0, wreq_cnt = 0, ivld_cnt = 0, dvld_cnt = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];

  axi_req_sched #(.WBUF_DEPTH(4), .LEN_W(4)) dut (
    .aclk(aclk), .areset(areset), .flush(flush),
    .ir_req(ir_req), .ir_addr(ir_addr), .ir_len(ir_len), .ir_ack(ir_ack),
    .ir_valid(ir_valid), .ir_last(ir_last), .ir_data(ir_data),
    .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack),
    .dr_valid(dr_valid), .dr_data(dr_data),
    .dw_req(dw_req), .dw_addr(dw_addr), .dw_data(dw_data), .dw_strb(dw_strb),
    .dw_ack(dw_ack), .wb_empty(wb_empty),
    .axir_ireq(axir_ireq), .axir_iaddr(axir_iaddr), .axir_ilen(axir_ilen),
    .axir_dreq(axir_dreq), .axir_daddr(axir_daddr),
    .axir_rid(axir_rid), .axir_rdy(axir_rdy), .axir_last(axir_last), .axir_data(axir_data),
    .axiw_req(axiw_req), .axiw_addr(axiw_addr), .axiw_data(axiw_data), .axiw_sel(axiw_sel),
    .axiw_rdy(axiw_rdy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (axir_ireq) ireq_cnt++;
    if (axir_dreq) dreq_cnt++;
    if (ir_valid)  ivld_cnt++;
    if (dr_valid)  dvld_cnt++;
    if (axiw_req) begin
      wreq_cnt++;
      wq_addr.push_back(axiw_addr);
      wq_data.push_back(axiw_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  task automatic test_reset();
    logic [235:0] ov;
    areset = 1'b1;
    tick(); tick();
    ov = {ir_ack, ir_valid, ir_last, ir_data, dr_ack, dr_valid, dr_data, axir_ireq, axir_iaddr,
          axir_ilen, axir_dreq, axir_daddr, axiw_req, axiw_addr, axiw_data, axiw_sel};
    n_chk++; if (ov !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", ov); end
    n_chk++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_wb_empty: got %b want 1", wb_empty); end
    areset = 1'b0;
    tick();
  endtask

  task automatic test_i_burst();
    int c0, v0;
    c0 = ireq_cnt;
    ir_addr = 32'h1FC0_0000; ir_len = 4'd3; ir_req = 1'b1;
    tick();
    n_chk++; if (ir_ack !== 1'b1 || axir_ireq !== 1'b1) begin n_fail++; $display("FAIL i_accept: ack=%b ireq=%b want 1/1", ir_ack, axir_ireq); end
    n_chk++; if (axir_iaddr !== 32'h1FC0_0000 || axir_ilen !== 4'd3) begin n_fail++; $display("FAIL i_addr_len: got %h/%0d want 1fc00000/3", axir_iaddr, axir_ilen); end
    ir_req = 1'b0;
    tick();
    n_chk++; if (ir_ack !== 1'b0 || axir_ireq !== 1'b0) begin n_fail++; $display("FAIL i_pulse_width: ack=%b ireq=%b want 0/0", ir_ack, axir_ireq); end
    v0 = ivld_cnt;
    for (int k = 0; k < 4; k++) begin
      axir_rdy = 1'b1; axir_rid = 1'b0; axir_data = 32'hA000_0000 + k; axir_last = (k == 3);
      tick();
      n_chk++;
      if (ir_valid !== 1'b1 || ir_data !== 32'hA000_0000 + k || ir_last !== (k == 3)) begin
        n_fail++; $display("FAIL i_beat%0d: valid=%b data=%h last=%b want 1/%h/%b", k, ir_valid, ir_data, ir_last, 32'hA000_0000 + k, k == 3);
      end
    end
    axir_rdy = 1'b0; axir_last = 1'b0;
    tick();
    n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL i_after_last: valid=%b want 0", ir_valid); end
    n_chk++; if (ireq_cnt - c0 != 1 || ivld_cnt - v0 != 4) begin n_fail++; $display("FAIL i_counts: ireq=%0d valid=%0d want 1/4", ireq_cnt - c0, ivld_cnt - v0); end
  endtask

  task automatic test_raw_hazard();
    int d0;
    bit got;
    logic [31:0] mem_word;
    d0 = dreq_cnt;
    dw_req = 1'b1; dw_addr = 32'h100; dw_data = 32'hDEAD_BEEF; dw_strb = 4'hF;
    n_chk++; if (dw_ack !== 1'b1) begin n_fail++; $display("FAIL raw_dw_ack: got %b want 1", dw_ack); end
    tick();
    dw_req = 1'b0; dr_req = 1'b1; dr_addr = 32'h100;
    tick();
    n_chk++; if (axiw_req !== 1'b1 || axiw_addr !== 32'h100 || axiw_data !== 32'hDEAD_BEEF || axiw_sel !== 32'hF) begin
      n_fail++; $display("FAIL raw_axiw: req=%b addr=%h data=%h sel=%h want 1/100/deadbeef/f", axiw_req, axiw_addr, axiw_data, axiw_sel);
    end
    n_chk++; if (dr_ack !== 1'b0 || wb_empty !== 1'b0) begin n_fail++; $display("FAIL raw_held: dr_ack=%b wb_empty=%b want 0/0", dr_ack, wb_empty); end
    repeat (3) tick();
    n_chk++; if (dreq_cnt != d0) begin n_fail++; $display("FAIL raw_no_early_dreq: got %0d pulses want 0", dreq_cnt - d0); end
    mem_word = axiw_data;
    axiw_rdy = 1'b1;
    tick();
    axiw_rdy = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (dr_ack === 1'b1) got = 1'b1; else tick();
    end
    n_chk++; if (!got || axir_dreq !== 1'b1 || axir_daddr !== 32'h100) begin
      n_fail++; $display("FAIL raw_issue: ack_seen=%b dreq=%b daddr=%h want 1/1/100", got, axir_dreq, axir_daddr);
    end
    dr_req = 1'b0;
    axir_rdy = 1'b1; axir_rid = 1'b1; axir_data = mem_word; axir_last = 1'b1;
    tick();
    axir_rdy = 1'b0; axir_last = 1'b0;
    n_chk++; if (dr_valid !== 1'b1 || dr_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL raw_data: valid=%b data=%h want 1/deadbeef", dr_valid, dr_data); end
    n_chk++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL raw_wb_empty: got %b want 1", wb_empty); end
    tick();
  endtask

  task automatic test_wbuf_full();
    wq_addr.delete(); wq_data.delete();
    axiw_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dw_req = 1'b1; dw_addr = 32'h200 + 4 * k; dw_data = 32'h1000_0000 + k; dw_strb = 4'hF;
      n_chk++; if (dw_ack !== 1'b1) begin n_fail++; $display("FAIL full_push%0d: dw_ack=%b want 1", k, dw_ack); end
      tick();
    end
    dw_addr = 32'h300; dw_data = 32'hBAD0_BAD0;
    n_chk++; if (dw_ack !== 1'b0 || wb_empty !== 1'b0) begin n_fail++; $display("FAIL full_5th: dw_ack=%b wb_empty=%b want 0/0", dw_ack, wb_empty); end
    tick();
    dw_req = 1'b0;
    axiw_rdy = 1'b1;
    repeat (12) tick();
    axiw_rdy = 1'b0;
    tick();
    n_chk++; if (wb_empty !== 1'b1 || dw_ack !== 1'b1) begin n_fail++; $display("FAIL full_drained: wb_empty=%b dw_ack=%b want 1/1", wb_empty, dw_ack); end
    n_chk++; if (wq_addr.size() != 4) begin n_fail++; $display("FAIL full_write_count: got %0d want 4", wq_addr.size()); end
    for (int k = 0; k < 4 && k < wq_addr.size(); k++) begin
      n_chk++;
      if (wq_addr[k] !== 32'h200 + 4 * k || wq_data[k] !== 32'h1000_0000 + k) begin
        n_fail++; $display("FAIL full_order%0d: addr=%h data=%h want %h/%h", k, wq_addr[k], wq_data[k], 32'h200 + 4 * k, 32'h1000_0000 + k);
      end
    end
  endtask

  task automatic test_flush_i();
    int v0;
    ir_addr = 32'h1FC0_0100; ir_len = 4'd3; ir_req = 1'b1;
    tick();
    n_chk++; if (ir_ack !== 1'b1) begin n_fail++; $display("FAIL fi_accept: ack=%b want 1", ir_ack); end
    ir_req = 1'b0;
    v0 = ivld_cnt;
    for (int k = 0; k < 4; k++) begin
      axir_rdy = 1'b1; axir_rid = 1'b0; axir_data = 32'hB000_0000 + k; axir_last = (k == 3);
      flush = (k == 1);
      tick();
      flush = 1'b0;
      n_chk++;
      if (ir_valid !== (k == 0)) begin n_fail++; $display("FAIL fi_beat%0d: valid=%b want %b", k, ir_valid, k == 0); end
    end
    axir_rdy = 1'b0; axir_last = 1'b0;
    n_chk++; if (ivld_cnt - v0 != 1) begin n_fail++; $display("FAIL fi_valid_count: got %0d want 1", ivld_cnt - v0); end
    ir_addr = 32'h1FC0_0200; ir_len = 4'd0; ir_req = 1'b1;
    tick();
    n_chk++; if (ir_ack !== 1'b1 || axir_ireq !== 1'b1 || axir_iaddr !== 32'h1FC0_0200) begin
      n_fail++; $display("FAIL fi_reissue: ack=%b ireq=%b addr=%h want 1/1/1fc00200", ir_ack, axir_ireq, axir_iaddr);
    end
    ir_req = 1'b0;
    axir_rdy = 1'b1; axir_rid = 1'b0; axir_data = 32'h55; axir_last = 1'b1;
    tick();
    axir_rdy = 1'b0; axir_last = 1'b0;
    n_chk++; if (ir_valid !== 1'b1 || ir_last !== 1'b1 || ir_data !== 32'h55) begin
      n_fail++; $display("FAIL fi_clean_beat: valid=%b last=%b data=%h want 1/1/55", ir_valid, ir_last, ir_data);
    end
    tick();
  endtask

  task automatic test_flush_both();
    int ci, cd;
    ci = ireq_cnt; cd = dreq_cnt;
    flush = 1'b1;
    ir_req = 1'b1; ir_addr = 32'h300; ir_len = 4'd0;
    dr_req = 1'b1; dr_addr = 32'h400;
    repeat (3) tick();
    n_chk++; if (ireq_cnt != ci || dreq_cnt != cd || ir_ack !== 1'b0 || dr_ack !== 1'b0) begin
      n_fail++; $display("FAIL fb_blocked: ireq=%0d dreq=%0d ir_ack=%b dr_ack=%b want 0/0/0/0", ireq_cnt - ci, dreq_cnt - cd, ir_ack, dr_ack);
    end
    flush = 1'b0;
    tick();
    n_chk++; if (axir_ireq !== 1'b1 || axir_dreq !== 1'b1) begin n_fail++; $display("FAIL fb_same_edge: ireq=%b dreq=%b want 1/1", axir_ireq, axir_dreq); end
    n_chk++; if (ir_ack !== 1'b1 || dr_ack !== 1'b1 || axir_daddr !== 32'h400) begin
      n_fail++; $display("FAIL fb_acks: ir_ack=%b dr_ack=%b daddr=%h want 1/1/400", ir_ack, dr_ack, axir_daddr);
    end
    ir_req = 1'b0; dr_req = 1'b0;
    axir_rdy = 1'b1; axir_rid = 1'b0; axir_data = 32'h0123; axir_last = 1'b1;
    tick();
    n_chk++; if (ir_valid !== 1'b1 || dr_valid !== 1'b0 || ir_data !== 32'h0123) begin
      n_fail++; $display("FAIL fb_i_route: ir_valid=%b dr_valid=%b data=%h want 1/0/123", ir_valid, dr_valid, ir_data);
    end
    axir_rid = 1'b1; axir_data = 32'h4567;
    tick();
    axir_rdy = 1'b0; axir_last = 1'b0;
    n_chk++; if (dr_valid !== 1'b1 || ir_valid !== 1'b0 || dr_data !== 32'h4567) begin
      n_fail++; $display("FAIL fb_d_route: dr_valid=%b ir_valid=%b data=%h want 1/0/4567", dr_valid, ir_valid, dr_data);
    end
    tick();
  endtask

  task automatic test_async_reset();
    logic [235:0] ov;
    int ci, cd, cw, cv;
    dw_req = 1'b1; dw_addr = 32'h500; dw_data = 32'h5555_5555; dw_strb = 4'h3;
    tick();
    dw_req = 1'b0; dr_req = 1'b1; dr_addr = 32'h600;
    tick();
    n_chk++; if (dr_ack !== 1'b1 || axiw_req !== 1'b1) begin n_fail++; $display("FAIL ar_setup: dr_ack=%b axiw_req=%b want 1/1", dr_ack, axiw_req); end
    dr_req = 1'b0;
    tick();
    #2 areset = 1'b1;
    #1;
    ov = {ir_ack, ir_valid, ir_last, ir_data, dr_ack, dr_valid, dr_data, axir_ireq, axir_iaddr,
          axir_ilen, axir_dreq, axir_daddr, axiw_req, axiw_addr, axiw_data, axiw_sel};
    n_chk++; if (ov !== '0) begin n_fail++; $display("FAIL ar_outputs: got %h want 0", ov); end
    n_chk++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL ar_wb_empty: got %b want 1", wb_empty); end
    ci = ireq_cnt; cd = dreq_cnt; cw = wreq_cnt; cv = dvld_cnt;
    axir_rdy = 1'b1; axir_rid = 1'b1; axir_data = 32'h7777; axir_last = 1'b1; axiw_rdy = 1'b1;
    tick(); tick();
    areset = 1'b0;
    repeat (3) tick();
    axir_rdy = 1'b0; axir_last = 1'b0; axiw_rdy = 1'b0;
    n_chk++; if (ireq_cnt != ci || dreq_cnt != cd || wreq_cnt != cw || dvld_cnt != cv) begin
      n_fail++; $display("FAIL ar_stray: ireq=%0d dreq=%0d wreq=%0d dvalid=%0d want 0/0/0/0", ireq_cnt - ci, dreq_cnt - cd, wreq_cnt - cw, dvld_cnt - cv);
    end
    n_chk++; if (wb_empty !== 1'b1) begin n_fail++; $display("FAIL ar_after_release: wb_empty=%b want 1", wb_empty); end
  endtask

  initial begin
    areset = 1'b1; flush = 1'b0;
    ir_req = 1'b0; ir_addr = '0; ir_len = '0;
    dr_req = 1'b0; dr_addr = '0;
    dw_req = 1'b0; dw_addr = '0; dw_data = '0; dw_strb = '0;
    axir_rid = 1'b0; axir_rdy = 1'b0; axir_last = 1'b0; axir_data = '0;
    axiw_rdy = 1'b0;
    test_reset();
    test_i_burst();
    test_raw_hazard();
    test_wbuf_full();
    test_flush_i();
    test_flush_both();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
